// File: rtl/mips_ex_pkg.sv
// Shared definitions for the MIPS execute stage.
// Holds the funct codes, the ALUOp encodings, the default iteration count of
// the multiply/divide unit and the muldiv opcode enum.
package mips_ex_pkg;

  localparam int MULDIV_CYCLES_DEF = 32;

  // ALUOp encodings coming from the decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  // R-type funct codes
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // Ordered so that funct[1:0] of 0x18..0x1B maps straight onto the enum
  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_MULU = 2'b01,
    MD_DIV  = 2'b10,
    MD_DIVU = 2'b11
  } md_op_e;

  // 0x18..0x1B all share funct[5:2] = 4'b0110
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Multiply is shift-add, divide is restoring division, both on operand
// magnitudes; signs are restored on the final iteration edge so HI/LO are
// written exactly MULDIV_CYCLES edges after the start edge.
// Ports:
//   clk, reset   clock, synchronous active-high reset (aborts, clears HI/LO)
//   start        begin an operation (honoured only while idle)
//   op           md_op_e encoding (MUL, MULU, DIV, DIVU)
//   a, b         operands (a = multiplier / dividend, b = multiplicand / divisor)
//   busy         operation in progress
//   hi, lo       architectural HI/LO
module muldiv_unit
  import mips_ex_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(MULDIV_CYCLES + 1);

  // FIXUP exists as a named phase but is merged into the last RUN edge
  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_e;

  state_e          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [31:0]     acc_hi, acc_lo, mag_b, dividend;
  logic            is_div, neg_q, neg_r, div_zero;
  logic            last;

  md_op_e          op_e;
  logic            op_signed, op_div;
  logic [31:0]     mag_a_in, mag_b_in;

  logic [32:0]     add_sum;
  logic [32:0]     div_sh;
  logic            div_ge;
  logic [31:0]     step_hi, step_lo;
  logic [63:0]     prod;
  logic [31:0]     fix_hi, fix_lo;

  assign busy = (state == RUN);
  assign last = (state == RUN) && (cnt == CW'(1));

  // operand decode at issue
  always_comb begin
    op_e      = md_op_e'(op);
    op_signed = (op_e == MD_MUL) || (op_e == MD_DIV);
    op_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
    mag_a_in  = (op_signed && a[31]) ? -a : a;
    mag_b_in  = (op_signed && b[31]) ? -b : b;
  end

  // one iteration; acc_hi:acc_lo is the product or remainder:quotient pair
  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);
    div_sh  = {acc_hi, acc_lo[31]};
    div_ge  = div_sh >= {1'b0, mag_b};
    if (is_div) begin
      // remainder stays below the divisor, so 32-bit subtraction is exact
      step_hi = div_ge ? (div_sh[31:0] - mag_b) : div_sh[31:0];
      step_lo = {acc_lo[30:0], div_ge};
    end else begin
      step_hi = add_sum[32:1];
      step_lo = {add_sum[0], acc_lo[31:1]};
    end
  end

  // sign restoration applied to the final iteration's result
  always_comb begin
    prod   = {step_hi, step_lo};
    fix_hi = step_hi;
    fix_lo = step_lo;
    if (div_zero) begin
      fix_lo = 32'hFFFF_FFFF;
      fix_hi = dividend;
    end else if (is_div) begin
      fix_lo = neg_q ? -step_lo : step_lo;
      fix_hi = neg_r ? -step_hi : step_hi;
    end else if (neg_q) begin
      prod   = -prod;
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        cnt      <= CW'(MULDIV_CYCLES);
        acc_hi   <= '0;
        acc_lo   <= mag_a_in;
        mag_b    <= mag_b_in;
        dividend <= a;
        is_div   <= op_div;
        neg_q    <= op_signed && (a[31] ^ b[31]);
        neg_r    <= op_signed && a[31];
        div_zero <= op_div && (b == 32'd0);
      end else if (state == RUN) begin
        cnt    <= cnt - CW'(1);
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (last) begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Forwards operands from EX/MEM and MEM/WB, runs the single-cycle ALU, hands
// multiply/divide to muldiv_unit and registers results into EX/MEM.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   *_rr_ex                  RR/EX pipeline register contents
//   dstn/RegWrite/wb_data_mem_wb  MEM/WB forwarding source
//   *_ex_mem                 EX/MEM pipeline register
//   stall_ex                 hold RR/EX and earlier stages this cycle
module ex_stage
  import mips_ex_pkg::*;
#(
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Read_Data_1_rr_ex,
  input  logic [31:0] Read_Data_2_rr_ex,
  input  logic [31:0] extended_rr_ex,
  input  logic [5:0]  funct_rr_ex,
  input  logic [1:0]  ALUOp_rr_ex,
  input  logic        ALUSrc_rr_ex,
  input  logic        jump_rr_ex,
  input  logic        MemRead_rr_ex,
  input  logic        MemWrite_rr_ex,
  input  logic        MemtoReg_rr_ex,
  input  logic        RegWrite_rr_ex,
  input  logic [4:0]  dstn_rr_ex,
  input  logic [4:0]  rs_rr_ex,
  input  logic [4:0]  rt_rr_ex,
  input  logic [4:0]  dstn_mem_wb,
  input  logic        RegWrite_mem_wb,
  input  logic [31:0] wb_data_mem_wb,
  output logic [31:0] alu_result_ex_mem,
  output logic [31:0] store_data_ex_mem,
  output logic [4:0]  dstn_ex_mem,
  output logic        MemRead_ex_mem,
  output logic        MemWrite_ex_mem,
  output logic        MemtoReg_ex_mem,
  output logic        RegWrite_ex_mem,
  output logic        stall_ex
);

  logic [31:0] fwd_a, fwd_b, alu_b, alu_res;
  logic [31:0] hi, lo;
  logic        busy, is_rtype, is_muldiv, is_mfx, md_start, bubble;

  // EX/MEM beats MEM/WB; register 0 never forwards
  always_comb begin
    fwd_a = Read_Data_1_rr_ex;
    if (RegWrite_ex_mem && dstn_ex_mem != 5'd0 && dstn_ex_mem == rs_rr_ex)
      fwd_a = alu_result_ex_mem;
    else if (RegWrite_mem_wb && dstn_mem_wb != 5'd0 && dstn_mem_wb == rs_rr_ex)
      fwd_a = wb_data_mem_wb;

    fwd_b = Read_Data_2_rr_ex;
    if (RegWrite_ex_mem && dstn_ex_mem != 5'd0 && dstn_ex_mem == rt_rr_ex)
      fwd_b = alu_result_ex_mem;
    else if (RegWrite_mem_wb && dstn_mem_wb != 5'd0 && dstn_mem_wb == rt_rr_ex)
      fwd_b = wb_data_mem_wb;
  end

  assign alu_b     = ALUSrc_rr_ex ? extended_rr_ex : fwd_b;
  assign is_rtype  = (ALUOp_rr_ex == ALU_RTYPE);
  assign is_muldiv = is_rtype && is_muldiv_funct(funct_rr_ex);
  assign is_mfx    = is_rtype && (funct_rr_ex == F_MFHI || funct_rr_ex == F_MFLO);
  assign stall_ex  = busy && (is_muldiv || is_mfx);
  assign md_start  = is_muldiv && !busy;
  assign bubble    = stall_ex || jump_rr_ex || is_muldiv;

  always_comb begin
    alu_res = 32'd0;
    case (ALUOp_rr_ex)
      ALU_ADD: alu_res = fwd_a + alu_b;
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_ORI: alu_res = fwd_a | {16'd0, extended_rr_ex[15:0]};
      default: begin
        case (funct_rr_ex)
          F_ADD, F_ADDU: alu_res = fwd_a + alu_b;
          F_SUB, F_SUBU: alu_res = fwd_a - alu_b;
          F_AND:         alu_res = fwd_a & alu_b;
          F_OR:          alu_res = fwd_a | alu_b;
          F_XOR:         alu_res = fwd_a ^ alu_b;
          F_NOR:         alu_res = ~(fwd_a | alu_b);
          F_SLT:         alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
          F_SLTU:        alu_res = {31'd0, fwd_a < alu_b};
          F_MFHI:        alu_res = hi;
          F_MFLO:        alu_res = lo;
          default:       alu_res = 32'd0;
        endcase
      end
    endcase
  end

  muldiv_unit #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (funct_rr_ex[1:0]),
    .a     (fwd_a),
    .b     (fwd_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      alu_result_ex_mem <= '0;
      store_data_ex_mem <= '0;
      dstn_ex_mem       <= '0;
      MemRead_ex_mem    <= 1'b0;
      MemWrite_ex_mem   <= 1'b0;
      MemtoReg_ex_mem   <= 1'b0;
      RegWrite_ex_mem   <= 1'b0;
    end else begin
      alu_result_ex_mem <= alu_res;
      store_data_ex_mem <= fwd_b;
      dstn_ex_mem       <= dstn_rr_ex;
      MemRead_ex_mem    <= MemRead_rr_ex;
      MemWrite_ex_mem   <= MemWrite_rr_ex;
      MemtoReg_ex_mem   <= MemtoReg_rr_ex;
      RegWrite_ex_mem   <= RegWrite_rr_ex;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: expected EX/MEM contents are queued as
// each instruction is presented and compared by a monitor after each edge;
// stall_ex and reset behaviour are checked inline by the scenario tasks.
module tb_ex_stage;
  import mips_ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Read_Data_1_rr_ex = '0, Read_Data_2_rr_ex = '0, extended_rr_ex = '0;
  logic [5:0]  funct_rr_ex = '0;
  logic [1:0]  ALUOp_rr_ex = '0;
  logic        ALUSrc_rr_ex = 0, jump_rr_ex = 0, MemRead_rr_ex = 0, MemWrite_rr_ex = 0;
  logic        MemtoReg_rr_ex = 0, RegWrite_rr_ex = 0;
  logic [4:0]  dstn_rr_ex = '0, rs_rr_ex = '0, rt_rr_ex = '0, dstn_mem_wb = '0;
  logic        RegWrite_mem_wb = 0;
  logic [31:0] wb_data_mem_wb = '0;
  logic [31:0] alu_result_ex_mem, store_data_ex_mem;
  logic [4:0]  dstn_ex_mem;
  logic        MemRead_ex_mem, MemWrite_ex_mem, MemtoReg_ex_mem, RegWrite_ex_mem, stall_ex;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .Read_Data_1_rr_ex(Read_Data_1_rr_ex), .Read_Data_2_rr_ex(Read_Data_2_rr_ex),
    .extended_rr_ex(extended_rr_ex), .funct_rr_ex(funct_rr_ex), .ALUOp_rr_ex(ALUOp_rr_ex),
    .ALUSrc_rr_ex(ALUSrc_rr_ex), .jump_rr_ex(jump_rr_ex), .MemRead_rr_ex(MemRead_rr_ex),
    .MemWrite_rr_ex(MemWrite_rr_ex), .MemtoReg_rr_ex(MemtoReg_rr_ex),
    .RegWrite_rr_ex(RegWrite_rr_ex), .dstn_rr_ex(dstn_rr_ex), .rs_rr_ex(rs_rr_ex),
    .rt_rr_ex(rt_rr_ex), .dstn_mem_wb(dstn_mem_wb), .RegWrite_mem_wb(RegWrite_mem_wb),
    .wb_data_mem_wb(wb_data_mem_wb), .alu_result_ex_mem(alu_result_ex_mem),
    .store_data_ex_mem(store_data_ex_mem), .dstn_ex_mem(dstn_ex_mem),
    .MemRead_ex_mem(MemRead_ex_mem), .MemWrite_ex_mem(MemWrite_ex_mem),
    .MemtoReg_ex_mem(MemtoReg_ex_mem), .RegWrite_ex_mem(RegWrite_ex_mem),
    .stall_ex(stall_ex)
  );

  typedef struct packed {
    logic [31:0] rd1, rd2, ext;
    logic [5:0]  funct;
    logic [1:0]  aluop;
    logic        alusrc, jump, mr, mw, m2r, rw;
    logic [4:0]  dstn, rs, rt, wb_d;
    logic        wb_rw;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic [31:0] alu, st;
    logic [4:0]  dstn;
    logic        mr, mw, m2r, rw;
  } exp_t;

  localparam exp_t BUBBLE = '0;

  exp_t exp_q[$];
  exp_t m_e, m_g;
  int   total = 0;
  int   bad = 0;

  // scoreboard monitor: one queued expectation per presented instruction
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      m_g = {alu_result_ex_mem, store_data_ex_mem, dstn_ex_mem,
             MemRead_ex_mem, MemWrite_ex_mem, MemtoReg_ex_mem, RegWrite_ex_mem};
      total++;
      if (m_g !== m_e) begin
        bad++;
        $display("FAIL exmem @%0t: got alu=%h st=%h dstn=%0d ctl=%b required alu=%h st=%h dstn=%0d ctl=%b",
                 $time, m_g.alu, m_g.st, m_g.dstn, {m_g.mr, m_g.mw, m_g.m2r, m_g.rw},
                 m_e.alu, m_e.st, m_e.dstn, {m_e.mr, m_e.mw, m_e.m2r, m_e.rw});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic in_t rt_i(input logic [5:0] fn, input logic [4:0] rs, rt, d,
                               input logic [31:0] a, b);
    in_t s;
    s = '0;
    s.funct = fn; s.aluop = ALU_RTYPE; s.rw = 1'b1;
    s.rs = rs; s.rt = rt; s.dstn = d; s.rd1 = a; s.rd2 = b;
    return s;
  endfunction

  function automatic exp_t ex_r(input logic [31:0] alu, st, input logic [4:0] d);
    exp_t e;
    e = '0;
    e.alu = alu; e.st = st; e.dstn = d; e.rw = 1'b1;
    return e;
  endfunction

  // present one instruction at the negedge and queue its EX/MEM expectation
  task automatic drive(input in_t s, input exp_t e);
    @(negedge clk);
    Read_Data_1_rr_ex = s.rd1; Read_Data_2_rr_ex = s.rd2; extended_rr_ex = s.ext;
    funct_rr_ex = s.funct; ALUOp_rr_ex = s.aluop; ALUSrc_rr_ex = s.alusrc;
    jump_rr_ex = s.jump; MemRead_rr_ex = s.mr; MemWrite_rr_ex = s.mw;
    MemtoReg_rr_ex = s.m2r; RegWrite_rr_ex = s.rw; dstn_rr_ex = s.dstn;
    rs_rr_ex = s.rs; rt_rr_ex = s.rt; dstn_mem_wb = s.wb_d;
    RegWrite_mem_wb = s.wb_rw; wb_data_mem_wb = s.wb_data;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({alu_result_ex_mem, store_data_ex_mem, dstn_ex_mem, MemRead_ex_mem, MemWrite_ex_mem,
         MemtoReg_ex_mem, RegWrite_ex_mem} !== 73'd0) begin
      bad++;
      $display("FAIL reset_outputs: got alu=%h dstn=%0d rw=%b required all zero",
               alu_result_ex_mem, dstn_ex_mem, RegWrite_ex_mem);
    end
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b required 0", stall_ex);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_forwarding;
    in_t s;
    drive(rt_i(F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7), ex_r(32'd12, 32'd7, 5'd3));
    // EX/MEM r3=12 must win over a stale MEM/WB r3=1
    s = rt_i(F_ADD, 5'd3, 5'd3, 5'd4, 32'd0, 32'd0);
    s.wb_d = 5'd3; s.wb_rw = 1'b1; s.wb_data = 32'd1;
    drive(s, ex_r(32'd24, 32'd12, 5'd4));
    // MEM/WB only
    s = rt_i(F_ADD, 5'd5, 5'd6, 5'd7, 32'd0, 32'd2);
    s.wb_d = 5'd5; s.wb_rw = 1'b1; s.wb_data = 32'd40;
    drive(s, ex_r(32'd42, 32'd2, 5'd7));
    // a write to r0 lands in EX/MEM but must never forward
    drive(rt_i(F_ADD, 5'd8, 5'd9, 5'd0, 32'd99, 32'd0), ex_r(32'd99, 32'd0, 5'd0));
    s = rt_i(F_ADD, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0);
    s.wb_d = 5'd0; s.wb_rw = 1'b1; s.wb_data = 32'd99;
    drive(s, ex_r(32'd0, 32'd0, 5'd10));
  endtask

  task automatic test_alu_rtype;
    logic [5:0]  fns [10];
    logic [31:0] exps[10];
    fns = '{F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_ADDU, 6'h3F};
    exps = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
             32'h0, 32'h1, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++)
      drive(rt_i(fns[i], 5'd11, 5'd12, 5'd13, 32'hFFFF_FFFF, 32'd1),
            ex_r(exps[i], 32'd1, 5'd13));
  endtask

  task automatic test_mem_and_imm;
    in_t  s;
    exp_t e;
    // lw address: 0x1000 + (-4)
    s = '0; s.aluop = ALU_ADD; s.alusrc = 1'b1; s.rd1 = 32'h1000; s.ext = 32'hFFFF_FFFC;
    s.rs = 5'd14; s.rt = 5'd15; s.dstn = 5'd15; s.mr = 1'b1; s.m2r = 1'b1; s.rw = 1'b1;
    e = ex_r(32'h0000_0FFC, 32'd0, 5'd15); e.mr = 1'b1; e.m2r = 1'b1;
    drive(s, e);
    // sw: store data is rt, not the immediate
    s = '0; s.aluop = ALU_ADD; s.alusrc = 1'b1; s.rd1 = 32'h2000; s.ext = 32'd8;
    s.rs = 5'd16; s.rt = 5'd17; s.rd2 = 32'hDEAD_BEEF; s.mw = 1'b1;
    e = '0; e.alu = 32'h2008; e.st = 32'hDEAD_BEEF; e.mw = 1'b1;
    drive(s, e);
    // ALUOp sub
    s = '0; s.aluop = ALU_SUB; s.rd1 = 32'd10; s.rd2 = 32'd3; s.rs = 5'd18; s.rt = 5'd19;
    s.dstn = 5'd20; s.rw = 1'b1;
    drive(s, ex_r(32'd7, 32'd3, 5'd20));
    // ori zero-extends the low half of the immediate
    s = '0; s.aluop = ALU_ORI; s.alusrc = 1'b1; s.rd1 = 32'h1234_0000; s.ext = 32'hFFFF_8001;
    s.rs = 5'd21; s.rt = 5'd22; s.rd2 = 32'h55; s.dstn = 5'd22; s.rw = 1'b1;
    drive(s, ex_r(32'h1234_8001, 32'h55, 5'd22));
    // jump leaves a bubble
    s = rt_i(F_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1); s.jump = 1'b1;
    drive(s, BUBBLE);
  endtask

  task automatic test_muldiv(input string name, input logic [5:0] fn,
                             input logic [31:0] a, b, exp_lo, exp_hi);
    drive(rt_i(fn, 5'd23, 5'd24, 5'd25, a, b), BUBBLE);
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL %s issue_stall: got %b required 0", name, stall_ex);
    end
    for (int i = 0; i < 32; i++) begin
      drive(rt_i(F_MFHI, 5'd0, 5'd0, 5'd26, 32'd0, 32'd0), BUBBLE);
      total++;
      if (stall_ex !== 1'b1) begin
        bad++;
        $display("FAIL %s mfhi_stall[%0d]: got %b required 1", name, i, stall_ex);
      end
    end
    drive(rt_i(F_MFHI, 5'd0, 5'd0, 5'd26, 32'd0, 32'd0), ex_r(exp_hi, 32'd0, 5'd26));
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL %s mfhi_release: got %b required 0", name, stall_ex);
    end
    drive(rt_i(F_MFLO, 5'd0, 5'd0, 5'd27, 32'd0, 32'd0), ex_r(exp_lo, 32'd0, 5'd27));
  endtask

  task automatic test_back_to_back;
    drive(rt_i(F_MULTU, 5'd23, 5'd24, 5'd0, 32'd3, 32'd5), BUBBLE);
    for (int i = 0; i < 32; i++) begin
      drive(rt_i(F_DIVU, 5'd23, 5'd24, 5'd0, 32'd100, 32'd7), BUBBLE);
      total++;
      if (stall_ex !== 1'b1) begin
        bad++;
        $display("FAIL b2b divu_stall[%0d]: got %b required 1", i, stall_ex);
      end
    end
    drive(rt_i(F_DIVU, 5'd23, 5'd24, 5'd0, 32'd100, 32'd7), BUBBLE);
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL b2b divu_issue: got %b required 0", stall_ex);
    end
    for (int i = 0; i < 32; i++) begin
      drive(rt_i(F_MFLO, 5'd0, 5'd0, 5'd27, 32'd0, 32'd0), BUBBLE);
      total++;
      if (stall_ex !== 1'b1) begin
        bad++;
        $display("FAIL b2b mflo_stall[%0d]: got %b required 1", i, stall_ex);
      end
    end
    drive(rt_i(F_MFLO, 5'd0, 5'd0, 5'd27, 32'd0, 32'd0), ex_r(32'd14, 32'd0, 5'd27));
    drive(rt_i(F_MFHI, 5'd0, 5'd0, 5'd26, 32'd0, 32'd0), ex_r(32'd2, 32'd0, 5'd26));
  endtask

  task automatic test_reset_mid_mult;
    in_t s;
    drive(rt_i(F_MULT, 5'd23, 5'd24, 5'd0, 32'd7, 32'hFFFF_FFFD), BUBBLE);
    // independent ALU ops keep flowing while the unit is busy
    for (int i = 0; i < 9; i++)
      drive(rt_i(F_ADD, 5'd28, 5'd29, 5'd30, 32'(i + 1), 32'd100),
            ex_r(32'(i + 101), 32'd100, 5'd30));
    s = rt_i(F_MFLO, 5'd0, 5'd0, 5'd31, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    funct_rr_ex = s.funct; ALUOp_rr_ex = s.aluop; dstn_rr_ex = s.dstn;
    @(posedge clk);
    #1;
    total++;
    if ({alu_result_ex_mem, store_data_ex_mem, dstn_ex_mem, MemRead_ex_mem, MemWrite_ex_mem,
         MemtoReg_ex_mem, RegWrite_ex_mem} !== 73'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got alu=%h dstn=%0d rw=%b required all zero",
               alu_result_ex_mem, dstn_ex_mem, RegWrite_ex_mem);
    end
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL midreset_stall: got %b required 0", stall_ex);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(s, ex_r(32'd0, 32'd0, 5'd31));
    total++;
    if (stall_ex !== 1'b0) begin
      bad++;
      $display("FAIL midreset_mflo_stall: got %b required 0", stall_ex);
    end
    drive(rt_i(F_MFHI, 5'd0, 5'd0, 5'd31, 32'd0, 32'd0), ex_r(32'd0, 32'd0, 5'd31));
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu_rtype();
    test_mem_and_imm();
    test_muldiv("mult",   F_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'hFFFF_FFFF);
    test_muldiv("div",    F_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    test_muldiv("divu0",  F_DIVU,  32'd7,          32'd0,         32'hFFFF_FFFF, 32'd7);
    test_muldiv("div0",   F_DIV,   32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9);
    test_muldiv("multu",  F_MULTU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFE, 32'd1);
    test_back_to_back();
    test_reset_mid_mult();
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, consuming everything the RR/EX pipeline register drives. It selects operands with EX/MEM and MEM/WB forwarding, runs the single-cycle ALU and an iterative 32-cycle multiply/divide unit with HI/LO registers, and registers results into the EX/MEM pipeline register. It raises `stall_ex` to hold upstream stages while a multiply/divide result is still pending.

## Interface
- `MULDIV_CYCLES`, default 32: iterations per multiply/divide.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `Read_Data_1_rr_ex`, `Read_Data_2_rr_ex`  in  32  register operands.
- `extended_rr_ex`  in  32  sign-extended immediate.
- `funct_rr_ex`  in  6  R-type funct.
- `ALUOp_rr_ex`  in  2  00 add, 01 sub, 10 R-type, 11 ori.
- `ALUSrc_rr_ex`, `jump_rr_ex`, `MemRead_rr_ex`, `MemWrite_rr_ex`, `MemtoReg_rr_ex`, `RegWrite_rr_ex`  in  1  controls.
- `dstn_rr_ex`, `rs_rr_ex`, `rt_rr_ex`  in  5  register numbers.
- `dstn_mem_wb`  in  5, `RegWrite_mem_wb`  in  1, `wb_data_mem_wb`  in  32: MEM/WB forwarding source.
- `alu_result_ex_mem`, `store_data_ex_mem`  out  32.
- `dstn_ex_mem`  out  5.
- `MemRead_ex_mem`, `MemWrite_ex_mem`, `MemtoReg_ex_mem`, `RegWrite_ex_mem`  out  1.
- `stall_ex`  out  1  hold RR/EX and earlier stages this cycle.

## Operation
- Forwarding, per operand, with rs for A and rt for B:
  - If `RegWrite_ex_mem` is set and `dstn_ex_mem` is nonzero and matches, take `alu_result_ex_mem`.
  - Otherwise, if the MEM/WB write is nonzero and matches, take `wb_data_mem_wb`.
  - Otherwise take the register read data.
  - Register 0 never forwards. Load-use hazards belong to the hazard unit, not this block.
- Operand B to ALU: `extended_rr_ex` if `ALUSrc_rr_ex`, else forwarded rt. `store_data_ex_mem` always takes forwarded rt.
- ALUOp 11: A OR zero-extended `extended_rr_ex[15:0]`.
- R-type funct codes:
  - Arithmetic/logic: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu.
  - 0x10 mfhi, 0x12 mflo.
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
  - Unknown funct gives result 0. All arithmetic wraps modulo 2^32; no overflow trap.
- Multiply/divide:
  - Issue starts the unit when it is idle. Multiply uses shift-add, divide uses restoring division, both on magnitudes.
  - Sign fix-up: product and quotient sign = sign A XOR sign B; remainder sign = dividend sign.
  - Results: LO = product[31:0] or quotient; HI = product[63:32] or remainder.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend.
  - Muldiv instructions write no GPR; the issuing instruction leaves a bubble in EX/MEM.
- `stall_ex = busy && (incoming is muldiv or mfhi/mflo)`. This is combinational.
- Bubble, meaning all EX/MEM controls 0 and `dstn_ex_mem` = 0, is loaded when any of these holds:
  - `stall_ex` is high;
  - `jump_rr_ex` is high;
  - the incoming instruction is a muldiv issue.
- Otherwise EX/MEM loads result, store data, dstn and controls.

## Timing
- Reset: all EX/MEM outputs 0, HI = LO = 0, busy = 0, `stall_ex` = 0.
- A reset during a multiply/divide aborts it; HI/LO end at 0.
- ALU ops: latency 1. The result appears at EX/MEM on the edge after the instruction is in EX.
- Muldiv issued on edge E:
  - Counter loads `MULDIV_CYCLES`; busy is high for the following `MULDIV_CYCLES` cycles.
  - HI/LO are written on edge E+`MULDIV_CYCLES`, and busy drops on the same edge.
  - An mfhi or mflo in EX during busy stalls. The first non-busy cycle reads the new HI/LO.
- Back-to-back muldiv: the second one stalls until idle, then issues.
- A stalled instruction stays presented at RR/EX because upstream holds it; EX/MEM receives bubbles meanwhile.

## Structure
- Shared package `mips_ex_pkg`:
  - funct constants;
  - ALUOp encodings;
  - `MULDIV_CYCLES` default;
  - muldiv opcode enum (MUL, MULU, DIV, DIVU).
- Sub-module `muldiv_unit`:
  - FSM with states IDLE, RUN, FIXUP (FIXUP is folded into the final RUN edge so the `MULDIV_CYCLES` timing holds);
  - iteration counter;
  - HI/LO registers;
  - ports start/op/a/b/busy/hi/lo.
- ALU and forwarding muxes stay in `ex_stage`.

## Test plan
- Forwarding priority: add r3 = 5+7, then add r4 = r3+r3 next cycle, with an MEM/WB stale r3 = 1 also present -> `alu_result_ex_mem` = 24 (EX/MEM wins). With dstn = 0 and value 99 -> no forward.
- Memory address: lw with ALUOp 00, A = 0x1000, imm = 0xFFFFFFFC -> result 0x00000FFC, MemRead_ex_mem = 1.
- Signed multiply: mult 7 × -3 -> after 32 cycles LO = 0xFFFFFFEB, HI = 0xFFFFFFFF. A following mfhi stalls exactly until busy drops, then returns 0xFFFFFFFF.
- Signed divide: div -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 7 / 0 -> LO = 0xFFFFFFFF, HI = 7.
- Back-to-back muldiv: multu immediately followed by divu -> `stall_ex` high 32 cycles, EX/MEM bubbles throughout, divu issues on the first idle cycle.
- Reset mid-mult at cycle 10 -> busy = 0, HI = LO = 0, all outputs 0 on the next edge; a following mflo returns 0 without stalling.
